data_ram_pipe: RTL and testbench
================================

// Module: data_ram_pipe
// PURPOSE
//  Parametrised, pipelined data memory for the load/store stage of the RISC-V core.
//  Replaces the combinational-read, fixed-32-bit data RAM with a registered-read RAM and a valid/ready request/response handshake.
//  Adds RISC-V size/sign handling (LB/LH/LW/LBU/LHU, SB/SH/SW), lane steering, and misalign/range error reporting.
//  Sits between the MEM stage and the memory array; the MEM stage stalls on req_ready.
// PARAMETERS
//  DATA_W  32    data path width in bits; multiple of 8, power of 2 (32 or 64)
//  ADDR_W  32    byte address width
//  DEPTH   1024  number of DATA_W-bit words; power of 2
//  (derived) LANES=DATA_W/8, LSB_W=$clog2(LANES), IDX_W=$clog2(DEPTH)
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       synchronous, active-high reset
//  req_valid   in   1       request present
//  req_ready   out  1       request accepted this cycle when req_valid&&req_ready
//  req_we      in   1       1=store, 0=load
//  req_addr    in   ADDR_W  byte address
//  req_size    in   2       0=byte,1=half,2=word,3=dword (dword legal only if DATA_W=64)
//  req_unsigned in  1       loads: 1=zero-extend, 0=sign-extend; ignored for stores
//  req_wdata   in   DATA_W  store data, right-aligned (bits [8*2^size-1:0] used)
//  resp_valid  out  1       response present
//  resp_ready  in   1       response consumed when resp_valid&&resp_ready
//  resp_rdata  out  DATA_W  load data, extended to DATA_W; 0 for stores and errors
//  resp_err    out  1       1=misaligned, illegal size, or out-of-range address
// BEHAVIOUR
//  - Reset (rst=1 at posedge): resp_valid=0, resp_rdata=0, resp_err=0; req_ready=0 while rst=1; memory contents not reset.
//  - rst has priority: a request presented while rst=1 is not accepted and does not write; a pending response is dropped.
//  - req_ready = !rst && (!resp_valid || resp_ready) (combinational; single response slot, full throughput when sink is ready).
//  - Accept at edge N -> resp_valid=1 from edge N (visible cycle N+1); latency exactly 1 cycle.
//  - Every accepted request (load or store) yields exactly one response; in-order by construction.
//  - resp_valid clears at edge when resp_ready=1 and no new accept; otherwise resp_* held stable while resp_ready=0.
//  - Error check at accept: err if addr[size-1:0]!=0 (misaligned), size illegal for DATA_W, or addr>>LSB_W >= DEPTH.
//  - Error requests: no memory write; response resp_err=1, resp_rdata=0.
//  - Store: lane = addr[LSB_W-1:0]; byte enables = (2^(2^size))-1 << lane; wdata replicated across lanes so enabled lanes get right-aligned data.
//  - Load: word read at accept edge; field at byte offset lane, width 2^size bytes, shifted to bit 0; extended per req_unsigned.
//  - Store at N followed by load to same word at N+1 returns the new data (write occurs at accept edge, before next read).
//  - Read data register updates only on accept; backpressure never changes resp_rdata.
//  - Word index = addr[LSB_W+IDX_W-1:LSB_W]; no wrap-around (range check prevents aliasing).
// STRUCTURE
//  - Size encodings (`SizeByte/`SizeHalf/`SizeWord/`SizeDword) and WriteEnable/ChipDisable-style constants go in Defines.vh.
//  - Sub-module byte_lane_bank: DEPTH x 8 synchronous RAM (we, idx, wdata, registered rdata), instantiated LANES times.
//  - Top: handshake/response register, error decode, byte-enable generation, load align+extend mux.
// TESTING
//  1. rst=1 2 cycles with req_valid=1, SW 0x4<-0xDEADBEEF -> req_ready=0, resp_valid=0; later LW 0x4 returns not 0xDEADBEEF-written-during-reset (write suppressed).
//  2. SW 0x10<-0x80FF7F01, then LB/LBU 0x11 -> 0x0000007F/0x0000007F; LB 0x13 -> 0xFFFFFF80; LHU 0x12 -> 0x000080FF; LH 0x12 -> 0xFFFF80FF.
//  3. SB 0x21<-0xAA over word 0x20=0x11223344 -> LW 0x20 = 0x1122AA44; SH 0x22<-0xBEEF -> LW 0x20 = 0xBEEFAA44.
//  4. LW 0x2 (misaligned), LH 0x1, size=3 at DATA_W=32, LW at DEPTH*4 -> resp_err=1, resp_rdata=0, memory unchanged.
//  5. Back-to-back 8 requests with resp_ready low on cycles 3-5 -> req_ready=0 those cycles, resp_* stable, all 8 responses in order, none lost/duplicated.
//  6. Store then load same address on consecutive cycles -> load returns stored value; repeat with DATA_W=64, SD/LD at 0x8 and LW 0xC sign-extended.

Source files
------------

// File: rtl/data_ram_pipe_pkg.sv
// Shared encodings for the pipelined load/store data memory.
// Access sizes follow the RISC-V funct3[1:0] encoding of loads and stores.
package data_ram_pipe_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    function automatic int size_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/data_ram_pipe_byte_lane_bank.sv
// One byte lane of the data memory: DEPTH x 8 synchronous RAM with registered read.
// The read register only moves when re is high, so a stalled response keeps its data.
module byte_lane_bank #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_ram_pipe.sv
// Pipelined RISC-V data memory: one-cycle registered read, single response slot,
// size/sign handling, lane steering and misalign/size/range error reporting.
module data_ram_pipe
    import data_ram_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int LANES = DATA_W / 8;
    localparam int LSB_W = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);

    // Handshake: a request is taken whenever the response slot is free or being drained.
    logic accept;
    assign req_ready = !rst && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;

    logic [LSB_W-1:0] lane;
    logic [IDX_W-1:0] idx;
    assign lane = req_addr[LSB_W-1:0];
    assign idx  = req_addr[LSB_W+IDX_W-1:LSB_W];

    logic misaligned;
    logic bad_size;
    logic out_of_range;
    logic err;

    always_comb begin
        misaligned = 1'b0;
        for (int b = 0; b < 3; b++) begin
            if (b < int'(req_size) && req_addr[b]) begin
                misaligned = 1'b1;
            end
        end
        bad_size     = (req_size == SIZE_DWORD) && (DATA_W < 64);
        out_of_range = (req_addr >> (LSB_W + IDX_W)) != '0;
        err          = misaligned || bad_size || out_of_range;
    end

    // Byte enables and store data replicated so every enabled lane sees its right-aligned byte.
    int               nbytes;
    logic [LANES-1:0] size_mask;
    logic [LANES-1:0] be;
    logic [7:0]       lane_wdata [LANES];

    always_comb begin
        nbytes = size_bytes(req_size);
        for (int j = 0; j < LANES; j++) begin
            size_mask[j]  = (j < nbytes);
            lane_wdata[j] = req_wdata[8*(j & (nbytes - 1)) +: 8];
        end
        be = size_mask << lane;
    end

    logic [7:0]        bank_rdata [LANES];
    logic [DATA_W-1:0] rword;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic lane_we;
        assign lane_we = (accept && req_we == WRITE_ENABLE && !err) ? be[g] : WRITE_DISABLE;

        byte_lane_bank #(
            .DEPTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_bank (
            .clk   (clk),
            .we    (lane_we),
            .re    (accept),
            .idx   (idx),
            .wdata (lane_wdata[g]),
            .rdata (bank_rdata[g])
        );

        assign rword[8*g +: 8] = bank_rdata[g];
    end

    logic             r_err;
    logic             r_load;
    logic [LSB_W-1:0] r_lane;
    logic [1:0]       r_size;
    logic             r_unsigned;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            r_err      <= 1'b0;
            r_load     <= 1'b0;
            r_lane     <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            r_err      <= err;
            r_load     <= !req_we;
            r_lane     <= lane;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // Load alignment works off the registered RAM word and the captured request attributes.
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] extended;
    logic              sign;
    int                fbits;

    always_comb begin
        shifted = rword >> {r_lane, 3'b000};
        fbits   = 8 << r_size;
        case (r_size)
            SIZE_BYTE: sign = shifted[7];
            SIZE_HALF: sign = shifted[15];
            SIZE_WORD: sign = shifted[31];
            default:   sign = shifted[DATA_W-1];
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            extended[i] = (i < fbits) ? shifted[i] : (!r_unsigned && sign);
        end
    end

    assign resp_rdata = (resp_valid && r_load && !r_err) ? extended : '0;
    assign resp_err   = resp_valid && r_err;

endmodule

// File: tb/tb_data_ram_pipe.sv
// Directed bench for data_ram_pipe: 32-bit and 64-bit instances, expected-queue scoreboard.
module tb_data_ram_pipe;

    localparam int W = 32;
    localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2, SD = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic [W-1:0]  req_wdata;
    logic          resp_valid, resp_ready, resp_err;
    logic [W-1:0]  resp_rdata;

    logic          req_valid_64, req_ready_64, req_we_64, req_unsigned_64;
    logic [31:0]   req_addr_64;
    logic [1:0]    req_size_64;
    logic [63:0]   req_wdata_64;
    logic          resp_valid_64, resp_ready_64, resp_err_64;
    logic [63:0]   resp_rdata_64;

    data_ram_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_ram_pipe #(.DATA_W(64), .ADDR_W(32), .DEPTH(1024)) dut_64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_64), .req_ready(req_ready_64), .req_we(req_we_64),
        .req_addr(req_addr_64), .req_size(req_size_64), .req_unsigned(req_unsigned_64),
        .req_wdata(req_wdata_64),
        .resp_valid(resp_valid_64), .resp_ready(resp_ready_64),
        .resp_rdata(resp_rdata_64), .resp_err(resp_err_64)
    );

    int checks = 0;
    int errors = 0;
    logic [W:0]  exp_q[$];
    logic [64:0] exp64_q[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Driver tasks: called at posedge+#1, hold the request until req_ready seen at negedge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [W-1:0] wdata,
                         input logic [W-1:0] exp_data, input logic exp_err);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("issue_timeout", 64'(req_ready), 64'd1);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            exp_q.push_back({exp_err, exp_data});
        end
        req_valid = 1'b0;
    endtask

    task automatic issue64(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [63:0] wdata,
                           input logic [63:0] exp_data, input logic exp_err);
        int n;
        req_valid_64 = 1'b1; req_we_64 = we; req_addr_64 = addr; req_size_64 = size;
        req_unsigned_64 = uns; req_wdata_64 = wdata;
        n = 0;
        @(negedge clk);
        while (!req_ready_64 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_64) begin
            check("issue64_timeout", 64'(req_ready_64), 64'd1);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            exp64_q.push_back({exp_err, exp_data});
        end
        req_valid_64 = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp64_q.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", 64'(exp_q.size() + exp64_q.size()), 64'd0);
    endtask

    // Monitors: pop on each handshake; a stalled response must hold its values.
    logic          held;
    logic [W:0]    held_val;
    logic [W:0]    exp_e;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held && resp_valid) begin
                check("stall_stable", 64'({resp_err, resp_rdata}), 64'(held_val));
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'(resp_valid), 64'd0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("resp_err", 64'(resp_err), 64'(exp_e[W]));
                    check("resp_rdata", 64'(resp_rdata), 64'(exp_e[W-1:0]));
                end
            end
            held     = resp_valid && !resp_ready;
            held_val = {resp_err, resp_rdata};
        end
    end

    logic [64:0] exp64_e;

    always @(negedge clk) begin
        if (!rst && resp_valid_64 && resp_ready_64) begin
            if (exp64_q.size() == 0) begin
                check("unexpected_resp64", 64'(resp_valid_64), 64'd0);
            end else begin
                exp64_e = exp64_q.pop_front();
                check("resp64_err", 64'(resp_err_64), 64'(exp64_e[64]));
                check("resp64_rdata", resp_rdata_64, exp64_e[63:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b1;
        req_valid_64 = 1'b0; req_we_64 = 1'b0; req_addr_64 = '0; req_size_64 = '0;
        req_unsigned_64 = 1'b0; req_wdata_64 = '0; resp_ready_64 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Store during reset must be ignored
        issue(1'b1, 32'h4, SW, 1'b0, 32'h12345678, 32'h0, 1'b0);
        wait_idle();
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_size = SW; req_wdata = 32'hDEADBEEF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_store_ready", 64'(req_ready), 64'd0);
            check("rst_store_valid", 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        req_valid = 1'b0;
        issue(1'b0, 32'h4, SW, 1'b0, '0, 32'h12345678, 1'b0);

        // Sign/zero extension
        issue(1'b1, 32'h10, SW, 1'b0, 32'h80FF7F01, 32'h0, 1'b0);
        issue(1'b0, 32'h11, SB, 1'b0, '0, 32'h0000007F, 1'b0);
        issue(1'b0, 32'h11, SB, 1'b1, '0, 32'h0000007F, 1'b0);
        issue(1'b0, 32'h13, SB, 1'b0, '0, 32'hFFFFFF80, 1'b0);
        issue(1'b0, 32'h13, SB, 1'b1, '0, 32'h00000080, 1'b0);
        issue(1'b0, 32'h12, SH, 1'b1, '0, 32'h000080FF, 1'b0);
        issue(1'b0, 32'h12, SH, 1'b0, '0, 32'hFFFF80FF, 1'b0);

        // Partial stores
        issue(1'b1, 32'h20, SW, 1'b0, 32'h11223344, 32'h0, 1'b0);
        issue(1'b1, 32'h21, SB, 1'b0, 32'hFFFFFFAA, 32'h0, 1'b0);
        issue(1'b0, 32'h20, SW, 1'b0, '0, 32'h1122AA44, 1'b0);
        issue(1'b1, 32'h22, SH, 1'b0, 32'h1234BEEF, 32'h0, 1'b0);
        issue(1'b0, 32'h20, SW, 1'b0, '0, 32'hBEEFAA44, 1'b0);

        // Error cases
        issue(1'b0, 32'h2, SW, 1'b0, '0, 32'h0, 1'b1);
        issue(1'b0, 32'h1, SH, 1'b0, '0, 32'h0, 1'b1);
        issue(1'b0, 32'h0, SD, 1'b0, '0, 32'h0, 1'b1);
        issue(1'b0, 32'h1000, SW, 1'b0, '0, 32'h0, 1'b1);
        issue(1'b1, 32'h12, SW, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(1'b1, 32'h1004, SW, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(1'b0, 32'h10, SW, 1'b0, '0, 32'h80FF7F01, 1'b0);
        issue(1'b0, 32'h4, SW, 1'b0, '0, 32'h12345678, 1'b0);
        wait_idle();

        // Back-to-back traffic with response backpressure on cycles 3-5
        fork
            begin
                issue(1'b1, 32'h40, SW, 1'b0, 32'h01020304, 32'h0, 1'b0);
                issue(1'b1, 32'h44, SW, 1'b0, 32'hC0D0E0F0, 32'h0, 1'b0);
                issue(1'b0, 32'h40, SW, 1'b0, '0, 32'h01020304, 1'b0);
                issue(1'b0, 32'h44, SW, 1'b0, '0, 32'hC0D0E0F0, 1'b0);
                issue(1'b1, 32'h41, SB, 1'b0, 32'h00000055, 32'h0, 1'b0);
                issue(1'b0, 32'h40, SW, 1'b0, '0, 32'h01025504, 1'b0);
                issue(1'b0, 32'h46, SH, 1'b1, '0, 32'h0000C0D0, 1'b0);
                issue(1'b0, 32'h44, SB, 1'b0, '0, 32'hFFFFFFF0, 1'b0);
            end
            begin
                for (int c = 0; c < 8; c++) begin
                    resp_ready = !(c >= 3 && c <= 5);
                    @(negedge clk);
                    if (!resp_ready) begin
                        check("stall_req_ready", 64'(req_ready), 64'd0);
                    end
                    @(posedge clk); #1;
                end
                resp_ready = 1'b1;
            end
        join
        wait_idle();

        // Store then load on consecutive cycles
        issue(1'b1, 32'h60, SW, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
        issue(1'b0, 32'h60, SW, 1'b0, '0, 32'hCAFEF00D, 1'b0);

        // 64-bit data path
        issue64(1'b1, 32'h8, SD, 1'b0, 64'h89ABCDEF01234567, 64'h0, 1'b0);
        issue64(1'b0, 32'h8, SD, 1'b0, '0, 64'h89ABCDEF01234567, 1'b0);
        issue64(1'b0, 32'hC, SW, 1'b0, '0, 64'hFFFFFFFF89ABCDEF, 1'b0);
        issue64(1'b0, 32'hC, SW, 1'b1, '0, 64'h0000000089ABCDEF, 1'b0);
        issue64(1'b0, 32'h8, SW, 1'b0, '0, 64'h0000000001234567, 1'b0);
        issue64(1'b0, 32'hF, SB, 1'b0, '0, 64'hFFFFFFFFFFFFFF89, 1'b0);
        issue64(1'b0, 32'h4, SD, 1'b0, '0, 64'h0, 1'b1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
